alu_ctrl_md: RTL and testbench
==============================

// Module: alu_ctrl_md
// PURPOSE
//  Next-generation ALU control for the RV32 core. Decodes ALUOp/func_field into ALU_SEL for base RV32I ops.
//  Also recognises RV32M (ALUOp=10, func7=0000001) and executes it on an internal iterative XLEN-wide
//  multiply/divide engine. While the engine is busy, the block stalls the pipeline through a handshake.
// PARAMETERS
//  XLEN      32  operand/result width (multiple of MUL_STEP, >=8)
//  MUL_STEP  1   multiplier bits retired per cycle (1, 2 or 4); mul iterations = XLEN/MUL_STEP
//  SEL_W     4   width of ALU_SEL
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      EX stage holds a valid instruction
//  kill        in   1      flush of EX instruction; aborts any md op
//  ALUOp       in   2      from main control unit
//  func_field  in   10     {func7, func3}
//  op_a        in   XLEN   rs1 value
//  op_b        in   XLEN   rs2 value
//  ALU_SEL     out  SEL_W  combinational ALU operation select
//  illegal     out  1      combinational; undefined ALUOp/func_field combination
//  is_md       out  1      combinational; decoded op is RV32M
//  stall       out  1      combinational; hold IF/ID/EX
//  busy        out  1      registered; engine in MUL or DIV state
//  md_done     out  1      registered 1-cycle pulse; md_result valid
//  md_result   out  XLEN   registered RV32M result; holds until next md_done
// BEHAVIOUR
//  Decode, base ops: add 0010, sub 0110, and 0000, or 0001, xor 0100, slt 1000, sltu 0111.
//   R-type shifts: sll 0011, srl 1001, sra 0101. I-type shifts: slli 1010, srli 1011, srai 1101.
//   ALUOp=00 -> 0010. Branches: beq/bne 0110, blt/bge 1000, bltu/bgeu 0111.
//  Decode, RV32M ops: ALU_SEL=1110; is_md=1; func3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//  Illegal combinations (incl. branch func3 010/011): ALU_SEL=1111, illegal=1. No z outputs.
//  FSM states: IDLE, MUL, DIV, DONE.
//   Accept: only in IDLE, when in_valid & is_md & !kill. Operands and func3 are latched at acceptance.
//   Accept transitions: IDLE->MUL for mul ops; IDLE->DIV for div/rem ops.
//   Fast path: divide by zero or signed overflow goes IDLE->DONE directly.
//   MUL: signed operands converted to magnitude and result sign recorded. Shift-add into a 2*XLEN
//    accumulator, MUL_STEP bits/cycle. Exits to DONE after XLEN/MUL_STEP cycles.
//   DIV: restoring divide on magnitudes, 1 bit/cycle. Exits to DONE after XLEN cycles.
//    Result sign: quotient = sign(a)^sign(b); remainder = sign(a).
//   DONE: md_result registered on entry. md_done=1 for one cycle, then ->IDLE.
//   md_done latency from acceptance edge: mul XLEN/MUL_STEP+1, div XLEN+1, fast path 1.
//  Result select: MUL low half. MULH/MULHSU/MULHU high half; MULHSU treats a as signed, b as unsigned.
//  Divide by zero: DIV/DIVU=all ones, REM/REMU=op_a.
//  Overflow: DIV(-2^(XLEN-1), -1) = -2^(XLEN-1); REM of the same = 0.
//  stall = in_valid & is_md & (state != DONE). The instruction is released in the cycle md_done=1.
//  Non-md instructions never stall and never change FSM state.
//  kill: IDLE next edge; no md_done; md_result unchanged. Priority: rst > kill > accept/iterate.
//  Reset: state=IDLE, busy=0, md_done=0, md_result=0. Any in-flight op is dropped.
//  Operand or func_field changes while busy are ignored.
// STRUCTURE
//  Package alu_pkg holds:
//   - ALU_SEL code localparams incl. SEL_MD=1110 and SEL_ILL=1111
//   - ALUOp codes and the RV32M func7/func3 codes
//   - the FSM state encoding
//  Top level holds the decode and the FSM/handshake.
//  Sub-module md_iter holds the latched operands, sign fix-up, shift-add/restoring datapath and step counter.
//   md_iter takes start/op/kill and returns a last-iteration flag.
// TESTING
//  Decode sweep:
//   - ALUOp=10, ff=0100000101 -> ALU_SEL=0101
//   - ALUOp=11, ff=0100000101 -> 1101
//   - ALUOp=01, ff=xxxxxxx010 -> illegal=1, ALU_SEL=1111
//  MUL 7 * 0xFFFFFFFD -> md_result=0xFFFFFFEB; md_done 33 cycles after accept; stall high 33 cycles.
//   MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; md_done at +33.
//   DIVU 100/7 -> 14.
//  Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each md_done at +1.
//   Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//  kill at +10 of a DIV -> busy=0 next cycle, no md_done. A MUL presented the cycle after is accepted.
//  rst at +5 of a MUL -> busy=0, md_done=0, md_result=0 next edge. Re-issued MUL completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared codes for the RV32 ALU control: ALU_SEL values, decode field codes
// and the multiply/divide sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_SLL  = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_SRA  = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SLTU = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SRL  = 4'b1001;
    localparam logic [3:0] SEL_SLLI = 4'b1010;
    localparam logic [3:0] SEL_SRLI = 4'b1011;
    localparam logic [3:0] SEL_SRAI = 4'b1101;
    localparam logic [3:0] SEL_MD   = 4'b1110;
    localparam logic [3:0] SEL_ILL  = 4'b1111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/md_iter.sv
// Iterative multiply/divide datapath: operand latch with sign fix-up, shared
// shift-add / restoring-divide register pair, and a terminal-count step counter.
module md_iter
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            kill_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            fast_o,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic                     a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0]          a_mag, b_mag, fast_res, iter_res;
    logic [2:0]               op_q;
    logic                     neg_q, rneg_q;
    logic [XLEN-1:0]          opnd_q, hi_q, lo_q, hi_n, lo_n;
    logic [CNT_W-1:0]         cnt_q;
    logic [XLEN+MUL_STEP-1:0] psum;
    logic [XLEN:0]            shifted, diff;
    logic [2*XLEN-1:0]        prod, prod_s;
    logic [XLEN-1:0]          quot_s, rem_s;

    always_comb begin
        // MUL/MULH/MULHSU take a as signed, MUL/MULH take b as signed; DIV/REM both
        a_neg = (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11)) & a_i[XLEN-1];
        b_neg = (op_i[2] ? ~op_i[0] : ~op_i[1]) & b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
        div0  = (b_i == '0);
        ovf   = ~op_i[0] & (a_i == MIN_NEG) & (b_i == '1);
        fast_o = op_i[2] & (div0 | ovf);
        if (div0) fast_res = op_i[1] ? a_i : '1;
        else      fast_res = op_i[1] ? '0 : MIN_NEG;
    end

    always_comb begin
        psum = {{MUL_STEP{1'b0}}, hi_q};
        for (int j = 0; j < MUL_STEP; j++) begin
            if (lo_q[j]) psum = psum + ({{MUL_STEP{1'b0}}, opnd_q} << j);
        end
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = psum[XLEN+MUL_STEP-1:MUL_STEP];
            lo_n = {psum[MUL_STEP-1:0], lo_q[XLEN-1:MUL_STEP]};
        end
    end

    // Result is formed from the post-step values so the final step lands directly
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        quot_s = neg_q ? -lo_n : lo_n;
        rem_s  = rneg_q ? -hi_n : hi_n;
        case (op_q)
            F3_MUL:                   iter_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                 iter_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:          iter_res = quot_s;
            default:                  iter_res = rem_s;
        endcase
        result_o = start_i ? fast_res : iter_res;
        last_o   = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
        end else if (start_i && !kill_i) begin
            op_q   <= op_i;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            hi_q   <= '0;
            opnd_q <= op_i[2] ? b_mag : a_mag;
            lo_q   <= op_i[2] ? a_mag : b_mag;
            cnt_q  <= op_i[2] ? DIV_LAST : MUL_LAST;
        end else if (step_i && !kill_i) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// RV32 ALU control: RV32I/RV32M decode to ALU_SEL, plus the sequencer and
// pipeline stall handshake for the iterative multiply/divide engine.
//  state | meaning
//  IDLE  | no md op in flight; accepts a valid, unkilled RV32M instruction
//  MUL   | shift-add iterations running
//  DIV   | restoring-divide iterations running
//  DONE  | md_result valid, md_done pulses, EX instruction released
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1,
    parameter int SEL_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             kill,
    input  logic [1:0]       ALUOp,
    input  logic [9:0]       func_field,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic [SEL_W-1:0] ALU_SEL,
    output logic             illegal,
    output logic             is_md,
    output logic             stall,
    output logic             busy,
    output logic             md_done,
    output logic [XLEN-1:0]  md_result
);
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [3:0]      sel_d;
    md_state_e       state_q, state_d;
    logic            accept, fast, last, load_res;
    logic [XLEN-1:0] res, md_result_q;

    assign f7 = func_field[9:3];
    assign f3 = func_field[2:0];

    always_comb begin
        sel_d = SEL_ILL;
        case (ALUOp)
            ALUOP_MEM: sel_d = SEL_ADD;
            ALUOP_BR: begin
                case (f3)
                    3'b000, 3'b001: sel_d = SEL_SUB;
                    3'b100, 3'b101: sel_d = SEL_SLT;
                    3'b110, 3'b111: sel_d = SEL_SLTU;
                    default:        sel_d = SEL_ILL;
                endcase
            end
            ALUOP_R: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  sel_d = SEL_ADD;
                        3'b001:  sel_d = SEL_SLL;
                        3'b010:  sel_d = SEL_SLT;
                        3'b011:  sel_d = SEL_SLTU;
                        3'b100:  sel_d = SEL_XOR;
                        3'b101:  sel_d = SEL_SRL;
                        3'b110:  sel_d = SEL_OR;
                        default: sel_d = SEL_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    sel_d = SEL_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    sel_d = SEL_SRA;
                end else if (f7 == F7_MD) begin
                    sel_d = SEL_MD;
                end
            end
            default: begin
                // I-type: func7 is immediate bits except for the shift forms
                case (f3)
                    3'b000:  sel_d = SEL_ADD;
                    3'b001:  sel_d = (f7 == F7_BASE) ? SEL_SLLI : SEL_ILL;
                    3'b010:  sel_d = SEL_SLT;
                    3'b011:  sel_d = SEL_SLTU;
                    3'b100:  sel_d = SEL_XOR;
                    3'b101:  sel_d = (f7 == F7_BASE) ? SEL_SRLI :
                                     (f7 == F7_ALT)  ? SEL_SRAI : SEL_ILL;
                    3'b110:  sel_d = SEL_OR;
                    default: sel_d = SEL_AND;
                endcase
            end
        endcase
    end

    assign ALU_SEL = SEL_W'(sel_d);
    assign illegal = (sel_d == SEL_ILL);
    assign is_md   = (sel_d == SEL_MD);
    assign accept  = (state_q == ST_IDLE) & in_valid & is_md & ~kill;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = fast ? ST_DONE : (f3[2] ? ST_DIV : ST_MUL);
                ST_MUL,
                ST_DIV:  if (last) state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall    = in_valid & is_md & (state_q != ST_DONE);
        busy     = (state_q == ST_MUL) | (state_q == ST_DIV);
        md_done  = (state_q == ST_DONE);
        load_res = ~kill & ((accept & fast) | (busy & last));
    end

    always_ff @(posedge clk) begin
        if (rst)           md_result_q <= '0;
        else if (load_res) md_result_q <= res;
    end

    assign md_result = md_result_q;

    md_iter #(
        .XLEN     (XLEN),
        .MUL_STEP (MUL_STEP)
    ) u_md_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept),
        .step_i   (busy),
        .kill_i   (kill),
        .op_i     (f3),
        .a_i      (op_a),
        .b_i      (op_b),
        .fast_o   (fast),
        .last_o   (last),
        .result_o (res)
    );

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode vectors plus scoreboarded RV32M ops,
// with a monitor that checks md_result and md_done timing on every pulse.
module tb_alu_ctrl_md;
    logic        clk = 1'b0;
    logic        rst, in_valid, kill;
    logic [1:0]  ALUOp;
    logic [9:0]  func_field;
    logic [31:0] op_a, op_b;
    logic [3:0]  ALU_SEL;
    logic        illegal, is_md, stall, busy, md_done;
    logic [31:0] md_result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [31:0] last_res = '0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       nm;
    } exp_t;
    exp_t sb[$];

    alu_ctrl_md #(.XLEN(32), .MUL_STEP(1), .SEL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .kill       (kill),
        .ALUOp      (ALUOp),
        .func_field (func_field),
        .op_a       (op_a),
        .op_b       (op_b),
        .ALU_SEL    (ALU_SEL),
        .illegal    (illegal),
        .is_md      (is_md),
        .stall      (stall),
        .busy       (busy),
        .md_done    (md_done),
        .md_result  (md_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every md_done must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_md_done: got md_done=1 result=%h, required no pulse", md_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_result"}, md_result, e.res);
                chk({e.nm, "_done_cycle"}, cyc, e.cyc);
                last_res = e.res;
            end
        end
    end

    task automatic chk_dec(input string nm, input logic [1:0] op, input logic [9:0] ff,
                           input logic [3:0] sel, input logic ill, input logic md);
        ALUOp = op;
        func_field = ff;
        #1;
        chk({nm, "_sel"}, {28'd0, ALU_SEL}, {28'd0, sel});
        chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, ill});
        chk({nm, "_is_md"}, {31'd0, is_md}, {31'd0, md});
    endtask

    // Called at posedge+1; presents the op, holds it while stalled, releases it
    task automatic md_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        exp_t e;
        in_valid   = 1'b1;
        ALUOp      = 2'b10;
        func_field = {7'b0000001, f3};
        op_a       = a;
        op_b       = b;
        e.res = exp;
        e.cyc = cyc + lat;
        e.nm  = nm;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            if (n == 2) begin
                op_a = ~a;
                op_b = a ^ 32'h5a5a_0f0f;
            end
            @(negedge clk);
        end
        chk({nm, "_stall_len"}, n, lat);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        ALUOp      = 2'b00;
        func_field = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0;
        ALUOp = 2'b00; func_field = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_md_done", {31'd0, md_done}, 32'd0);
        chk("reset_md_result", md_result, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        chk_dec("srai_r_sra", 2'b10, 10'b0100000_101, 4'b0101, 1'b0, 1'b0);
        chk_dec("i_srai",     2'b11, 10'b0100000_101, 4'b1101, 1'b0, 1'b0);
        chk_dec("br_f3_010",  2'b01, 10'b1010101_010, 4'b1111, 1'b1, 1'b0);
        chk_dec("br_f3_011",  2'b01, 10'b0000000_011, 4'b1111, 1'b1, 1'b0);
        chk_dec("br_bltu",    2'b01, 10'b0110011_110, 4'b0111, 1'b0, 1'b0);
        chk_dec("mem_add",    2'b00, 10'b1111111_111, 4'b0010, 1'b0, 1'b0);
        chk_dec("r_sltu",     2'b10, 10'b0000000_011, 4'b0111, 1'b0, 1'b0);
        chk_dec("r_sll",      2'b10, 10'b0000000_001, 4'b0011, 1'b0, 1'b0);
        chk_dec("r_alt_slt",  2'b10, 10'b0100000_010, 4'b1111, 1'b1, 1'b0);
        chk_dec("i_slli",     2'b11, 10'b0000000_001, 4'b1010, 1'b0, 1'b0);
        chk_dec("i_slli_bad", 2'b11, 10'b0100000_001, 4'b1111, 1'b1, 1'b0);
        chk_dec("i_sltiu",    2'b11, 10'b1010101_011, 4'b0111, 1'b0, 1'b0);
        chk_dec("r_md_div",   2'b10, 10'b0000001_100, 4'b1110, 1'b0, 1'b1);

        // A valid base op must not stall nor start the engine
        @(posedge clk);
        #1;
        in_valid = 1'b1; ALUOp = 2'b10; func_field = 10'b0100000_000;
        #1;
        chk("base_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("base_no_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0; ALUOp = 2'b00; func_field = '0;

        md_op("mul",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        md_op("mulhu",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        md_op("mulh",      3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        md_op("mulhsu",    3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        md_op("div",       3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        md_op("rem",       3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        md_op("divu",      3'b101, 32'd100,        32'd7,         32'd14,        33);
        md_op("remu",      3'b111, 32'd100,        32'd7,         32'd2,         33);
        md_op("divu_by0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        md_op("remu_by0",  3'b111, 32'd5,          32'd0,         32'd5,         1);
        md_op("div_by0",   3'b100, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        md_op("rem_by0",   3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
        md_op("div_ovf",   3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        md_op("rem_ovf",   3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // kill at +10 of a DIV
        in_valid = 1'b1; ALUOp = 2'b10; func_field = 10'b0000001_100;
        op_a = 32'd1000; op_b = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        chk("kill_pre_busy", {31'd0, busy}, 32'd1);
        kill = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        chk("kill_md_done", {31'd0, md_done}, 32'd0);
        chk("kill_md_result", md_result, last_res);
        md_op("mul_after_kill", 3'b000, 32'd6, 32'd7, 32'd42, 33);

        // rst at +5 of a MUL
        in_valid = 1'b1; ALUOp = 2'b10; func_field = 10'b0000001_000;
        op_a = 32'd9; op_b = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_md_done", {31'd0, md_done}, 32'd0);
        chk("rst_md_result", md_result, 32'd0);
        md_op("mul_after_rst", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 33);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
